mc_control_unit: RTL and testbench

MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

---
 rtl/cpu_types_pkg.sv | 46 ++++
 rtl/mc_control_unit_if.sv | 15 +
 rtl/mc_decode.sv | 61 ++++++
 rtl/mc_control_unit.sv | 131 +++++++++++++
 tb/tb_mc_control_unit.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared state, ALU-op, class types and opcode/funct constants for the multicycle control unit
package cpu_types_pkg;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} mc_state_t;

    typedef enum logic [3:0] {
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_ADD, ALU_SUB, ALU_AND,
        ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU
    } aluop_t;

    typedef enum logic [2:0] {
        CLS_ALU, CLS_LOAD, CLS_STORE, CLS_STORE_WB, CLS_BRANCH, CLS_HALT
    } instr_cls_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_LL    = 6'h30;
    localparam logic [5:0] OP_SC    = 6'h38;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

endpackage

// File: rtl/mc_control_unit_if.sv
// rtl/mc_control_unit_if.sv - instruction/data memory request bundle between control unit (master) and memory (slave)
interface mc_control_unit_if #(
    parameter int WORD_W = 32
);
    logic [WORD_W-1:0] instr;
    logic              ihit;
    logic              dhit;
    logic              iREN;
    logic              dREN;
    logic              dWEN;
    logic              datomic;

    modport master (input instr, ihit, dhit, output iREN, dREN, dWEN, datomic);
    modport slave  (output instr, ihit, dhit, input iREN, dREN, dWEN, datomic);
endinterface

// File: rtl/mc_decode.sv
// rtl/mc_decode.sv - combinational opcode/funct to ALU-op and instruction class decode
// MC_CU_ATOMIC_EN: LL/SC decode as atomic (SC writes back a success flag); otherwise as LW/SW.
module mc_decode
    import cpu_types_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    output aluop_t     o_aluop,
    output instr_cls_t o_cls,
    output logic       o_atomic
);
    always_comb begin
        o_aluop  = ALU_ADD;
        o_cls    = CLS_ALU;
        o_atomic = 1'b0;
        case (i_opcode)
            OP_RTYPE: begin
                case (i_funct)
                    FN_SLL:          o_aluop = ALU_SLL;
                    FN_SRL:          o_aluop = ALU_SRL;
                    FN_SRA:          o_aluop = ALU_SRA;
                    FN_SUB, FN_SUBU: o_aluop = ALU_SUB;
                    FN_AND:          o_aluop = ALU_AND;
                    FN_OR:           o_aluop = ALU_OR;
                    FN_XOR:          o_aluop = ALU_XOR;
                    FN_NOR:          o_aluop = ALU_NOR;
                    FN_SLT:          o_aluop = ALU_SLT;
                    FN_SLTU:         o_aluop = ALU_SLTU;
                    default:         o_aluop = ALU_ADD;
                endcase
            end
            OP_LW:  o_cls = CLS_LOAD;
            OP_SW:  o_cls = CLS_STORE;
`ifdef MC_CU_ATOMIC_EN
            OP_LL: begin
                o_cls    = CLS_LOAD;
                o_atomic = 1'b1;
            end
            OP_SC: begin
                o_cls    = CLS_STORE_WB;
                o_atomic = 1'b1;
            end
`else
            OP_LL:  o_cls = CLS_LOAD;
            OP_SC:  o_cls = CLS_STORE;
`endif
            OP_BEQ, OP_BNE: begin
                o_cls   = CLS_BRANCH;
                o_aluop = ALU_SUB;
            end
            OP_J:     o_cls = CLS_BRANCH;
            OP_HALT:  o_cls = CLS_HALT;
            OP_SLTI:  o_aluop = ALU_SLT;
            OP_SLTIU: o_aluop = ALU_SLTU;
            OP_ANDI:  o_aluop = ALU_AND;
            OP_ORI:   o_aluop = ALU_OR;
            OP_XORI:  o_aluop = ALU_XOR;
            default:  o_aluop = ALU_ADD;
        endcase
    end
endmodule

// File: rtl/mc_control_unit.sv
// rtl/mc_control_unit.sv - multicycle FETCH/DECODE/EXEC/MEM/WB/HALT controller with memory wait timeout
module mc_control_unit
    import cpu_types_pkg::*;
#(
    parameter int WORD_W   = 32,
    parameter int CNT_W    = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic              CLK,
    input  logic              RST,
    mc_control_unit_if.master bus,
    output logic              irWEN,
    output logic              pcWEN,
    output logic              WEN,
    output aluop_t            ALUOP,
    output logic              halt,
    output logic              err,
    output mc_state_t         state,
    output logic [CNT_W-1:0]  instr_cnt
);
    localparam int WAIT_W = $clog2(MAX_WAIT + 2);
    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT);

    mc_state_t         r_state;
    logic [WORD_W-1:0] r_ir;
    logic [CNT_W-1:0]  r_cnt;
    logic [WAIT_W-1:0] r_wait;
    logic              r_err, r_halt, r_iren, r_dren, r_dwen, r_datomic, r_wen, r_pc_br;
    aluop_t            r_aluop;

    mc_state_t  w_next;
    logic       w_timeout;
    aluop_t     w_aluop;
    instr_cls_t w_cls;
    logic       w_atomic;
    logic       w_unused_ir;

    mc_decode u_decode (
        .i_opcode (r_ir[31:26]),
        .i_funct  (r_ir[5:0]),
        .o_aluop  (w_aluop),
        .o_cls    (w_cls),
        .o_atomic (w_atomic)
    );

    always_comb begin
        w_next    = r_state;
        w_timeout = 1'b0;
        case (r_state)
            FETCH: begin
                if (bus.ihit)                  w_next = DECODE;
                else if (r_wait == WAIT_LIM) begin
                    w_next    = HALT;
                    w_timeout = 1'b1;
                end
            end
            DECODE: w_next = (w_cls == CLS_HALT) ? HALT : EXEC;
            EXEC: begin
                case (w_cls)
                    CLS_LOAD, CLS_STORE, CLS_STORE_WB: w_next = MEM;
                    CLS_BRANCH:                        w_next = FETCH;
                    default:                           w_next = WB;
                endcase
            end
            MEM: begin
                if (bus.dhit)                  w_next = (w_cls == CLS_STORE) ? FETCH : WB;
                else if (r_wait == WAIT_LIM) begin
                    w_next    = HALT;
                    w_timeout = 1'b1;
                end
            end
            WB:      w_next = FETCH;
            HALT:    w_next = HALT;
            default: w_next = FETCH;
        endcase
    end

    // Strobes are registered from the next state so they line up with the state they belong to.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= FETCH;
            r_ir      <= '0;
            r_cnt     <= '0;
            r_wait    <= '0;
            r_err     <= 1'b0;
            r_halt    <= 1'b0;
            r_iren    <= 1'b1;
            r_dren    <= 1'b0;
            r_dwen    <= 1'b0;
            r_datomic <= 1'b0;
            r_wen     <= 1'b0;
            r_pc_br   <= 1'b0;
            r_aluop   <= ALU_ADD;
        end else begin
            r_state <= w_next;
            if (r_state == FETCH && bus.ihit)
                r_ir <= bus.instr;
            if (w_next == FETCH && (r_state == EXEC || r_state == MEM || r_state == WB))
                r_cnt <= r_cnt + CNT_W'(1);
            if (w_next != r_state)
                r_wait <= '0;
            else if (r_state == FETCH || r_state == MEM)
                r_wait <= r_wait + WAIT_W'(1);
            if (w_timeout)
                r_err <= 1'b1;
            r_halt    <= (w_next == HALT);
            r_iren    <= (w_next == FETCH);
            r_dren    <= (w_next == MEM) && (w_cls == CLS_LOAD);
            r_dwen    <= (w_next == MEM) && (w_cls == CLS_STORE || w_cls == CLS_STORE_WB);
            r_datomic <= (w_next == MEM) && w_atomic;
            r_wen     <= (w_next == WB);
            r_pc_br   <= (w_next == EXEC) && (w_cls == CLS_BRANCH);
            r_aluop   <= (w_next == EXEC) ? w_aluop : ALU_ADD;
        end
    end

    assign w_unused_ir = ^r_ir;

    assign bus.iREN    = r_iren;
    assign bus.dREN    = r_dren;
    assign bus.dWEN    = r_dwen;
    assign bus.datomic = r_datomic;
    assign irWEN       = (r_state == FETCH) && bus.ihit;
    assign pcWEN       = irWEN || r_pc_br;
    assign WEN         = r_wen;
    assign ALUOP       = r_aluop;
    assign halt        = r_halt;
    assign err         = r_err;
    assign state       = r_state;
    assign instr_cnt   = r_cnt;
endmodule

// File: tb/tb_mc_control_unit.sv
// tb/tb_mc_control_unit.sv - randomized cycle-level bench for mc_control_unit against a per-instruction phase model (MC_CU_ATOMIC_EN aware)
module tb_mc_control_unit;
    import cpu_types_pkg::*;

    localparam int CNT_W    = 4;
    localparam int MAX_WAIT = 15;

    logic             CLK = 1'b0;
    logic             RST;
    logic             irWEN, pcWEN, WEN, halt, err;
    aluop_t           ALUOP;
    mc_state_t        state;
    logic [CNT_W-1:0] instr_cnt;

    int n_checks  = 0;
    int n_errors  = 0;
    int model_cnt = 0;

    always #5 CLK = ~CLK;

    mc_control_unit_if #(.WORD_W(32)) bus ();

    mc_control_unit #(.WORD_W(32), .CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .bus       (bus),
        .irWEN     (irWEN),
        .pcWEN     (pcWEN),
        .WEN       (WEN),
        .ALUOP     (ALUOP),
        .halt      (halt),
        .err       (err),
        .state     (state),
        .instr_cnt (instr_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] obs();
        return {state, bus.iREN, bus.dREN, bus.dWEN, bus.datomic, irWEN, pcWEN, WEN, halt, err};
    endfunction

    function automatic logic [11:0] ev(input mc_state_t s, input bit ir, input bit dr, input bit dw,
                                       input bit da, input bit irw, input bit pcw, input bit wen,
                                       input bit h, input bit e);
        return {s, ir, dr, dw, da, irw, pcw, wen, h, e};
    endfunction

    function automatic aluop_t ref_alu(input logic [5:0] op, input logic [5:0] fn);
        if (op == OP_BEQ || op == OP_BNE) return ALU_SUB;
        if (op != OP_RTYPE) return ALU_ADD;
        case (fn)
            FN_SLL:          return ALU_SLL;
            FN_SRL:          return ALU_SRL;
            FN_SRA:          return ALU_SRA;
            FN_SUB, FN_SUBU: return ALU_SUB;
            FN_AND:          return ALU_AND;
            FN_OR:           return ALU_OR;
            FN_XOR:          return ALU_XOR;
            FN_NOR:          return ALU_NOR;
            FN_SLT:          return ALU_SLT;
            FN_SLTU:         return ALU_SLTU;
            default:         return ALU_ADD;
        endcase
    endfunction

    task automatic drive(input bit ih, input bit dh, input logic [31:0] ins);
        @(negedge CLK);
        bus.ihit  = ih;
        bus.dhit  = dh;
        bus.instr = ins;
        #1;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST      = 1'b1;
        bus.ihit = 1'b0;
        bus.dhit = 1'b0;
        @(posedge CLK);
        #1 RST    = 1'b0;
        model_cnt = 0;
    endtask

    task automatic expect_halt(input string tag, input bit e, input int n);
        for (int k = 0; k < n; k++) begin
            drive(1'($urandom), 1'($urandom), $urandom);
            check(tag, 64'(obs()), 64'(ev(HALT, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, e)));
        end
    endtask

    // Walks one instruction through its phases; a wait count above MAX_WAIT means "never hit".
    task automatic run_instr(input logic [31:0] ins, input int iw, input int dw, input int rst_mem,
                             output bit stopped);
        logic [5:0] op, fn;
        bit ld, st, br, hl, at, wb, hit;
        op = ins[31:26];
        fn = ins[5:0];
        ld = (op == OP_LW) || (op == OP_LL);
        st = (op == OP_SW) || (op == OP_SC);
        br = (op == OP_BEQ) || (op == OP_BNE) || (op == OP_J);
        hl = (op == OP_HALT);
        at = 1'b0;
`ifdef MC_CU_ATOMIC_EN
        at = (op == OP_LL) || (op == OP_SC);
`endif
        wb = (!br && !st) || (at && st);
        stopped = 1'b0;

        for (int k = 0; k <= iw && k <= MAX_WAIT; k++) begin
            hit = (k == iw);
            drive(hit, 1'($urandom), hit ? ins : $urandom);
            check("fetch", 64'(obs()), 64'(ev(FETCH, 1'b1, 1'b0, 1'b0, 1'b0, hit, hit, 1'b0, 1'b0, 1'b0)));
            if (k == 0) check("instr_cnt", 64'(instr_cnt), 64'(model_cnt));
        end
        if (iw > MAX_WAIT) begin
            expect_halt("fetch_timeout", 1'b1, 4);
            stopped = 1'b1;
            return;
        end

        drive(1'($urandom), 1'($urandom), $urandom);
        check("decode", 64'(obs()), 64'(ev(DECODE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)));
        if (hl) begin
            expect_halt("halt_instr", 1'b0, 20);
            check("halt_cnt", 64'(instr_cnt), 64'(model_cnt));
            stopped = 1'b1;
            return;
        end

        drive(1'($urandom), 1'($urandom), $urandom);
        check("exec", 64'(obs()), 64'(ev(EXEC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, br, 1'b0, 1'b0, 1'b0)));
        if (op == OP_RTYPE || op == OP_LW || op == OP_SW || op == OP_BEQ || op == OP_BNE)
            check("aluop", 64'(ALUOP), 64'(ref_alu(op, fn)));

        if (ld || st) begin
            for (int k = 0; k <= dw && k <= MAX_WAIT; k++) begin
                if (k == rst_mem) begin
                    @(negedge CLK);
                    RST      = 1'b1;
                    bus.dhit = 1'b0;
                    @(negedge CLK);
                    RST      = 1'b0;
                    bus.ihit = 1'b0;
                    #1;
                    check("rst_mid_mem", 64'(obs()), 64'(ev(FETCH, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)));
                    check("rst_cnt", 64'(instr_cnt), 64'd0);
                    model_cnt = 0;
                    stopped   = 1'b1;
                    return;
                end
                hit = (k == dw);
                drive(1'($urandom), hit, $urandom);
                check("mem", 64'(obs()), 64'(ev(MEM, 1'b0, ld, st, at, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)));
            end
            if (dw > MAX_WAIT) begin
                expect_halt("mem_timeout", 1'b1, 4);
                stopped = 1'b1;
                return;
            end
        end

        if (wb) begin
            drive(1'($urandom), 1'($urandom), $urandom);
            check("wb", 64'(obs()), 64'(ev(WB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0)));
        end
        model_cnt = (model_cnt + 1) % (1 << CNT_W);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] op, fn;
        case ($urandom_range(0, 11))
            0, 1, 2: op = OP_RTYPE;
            3:       op = OP_J;
            4:       op = OP_BEQ;
            5:       op = OP_BNE;
            6:       op = OP_ADDI;
            7:       op = OP_LW;
            8:       op = OP_SW;
            9:       op = OP_LL;
            10:      op = OP_SC;
            default: op = 6'($urandom_range(1, 62));
        endcase
        case ($urandom_range(0, 12))
            0:       fn = FN_SLL;
            1:       fn = FN_SRL;
            2:       fn = FN_SRA;
            3:       fn = FN_ADD;
            4:       fn = FN_ADDU;
            5:       fn = FN_SUB;
            6:       fn = FN_SUBU;
            7:       fn = FN_AND;
            8:       fn = FN_OR;
            9:       fn = FN_XOR;
            10:      fn = FN_NOR;
            11:      fn = FN_SLT;
            default: fn = FN_SLTU;
        endcase
        if (op != OP_RTYPE) fn = 6'($urandom);
        return {op, 20'($urandom), fn};
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit stopped;
        int iw, dw;
        logic [31:0] ins;
        RST       = 1'b1;
        bus.ihit  = 1'b0;
        bus.dhit  = 1'b0;
        bus.instr = '0;
        do_reset();

        run_instr({OP_RTYPE, 20'h43180, FN_ADDU}, 0, 0, -1, stopped);
        run_instr({OP_LW, 26'h0221_0010}, 0, 3, -1, stopped);
        run_instr({OP_SW, 26'h0221_0014}, 2, 0, -1, stopped);
        run_instr({OP_BEQ, 26'h0022_0003}, 0, 0, -1, stopped);
        run_instr({OP_J, 26'h000_0040}, 1, 0, -1, stopped);
        run_instr({OP_LL, 26'h0221_0000}, 0, 2, -1, stopped);
        run_instr({OP_SC, 26'h0221_0000}, 0, 1, -1, stopped);
        run_instr({OP_RTYPE, 20'h43180, FN_SUBU}, MAX_WAIT, 0, -1, stopped);
        run_instr({OP_LW, 26'h0221_0004}, 0, MAX_WAIT, -1, stopped);

        run_instr({OP_RTYPE, 20'h00000, FN_OR}, MAX_WAIT + 1, 0, -1, stopped);
        do_reset();
        run_instr({OP_SW, 26'h0221_0008}, 0, MAX_WAIT + 1, -1, stopped);
        do_reset();
        run_instr({OP_RTYPE, 20'h1, FN_AND}, 0, 0, -1, stopped);
        run_instr(32'hFC00_0000, 0, 0, -1, stopped);
        do_reset();
        run_instr({OP_LW, 26'h0221_000C}, 1, 10, 5, stopped);
        run_instr({OP_BNE, 26'h0022_0001}, 3, 0, -1, stopped);

        for (int n = 0; n < 90; n++) begin
            ins = rand_instr();
            iw  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, MAX_WAIT)) : int'($urandom_range(0, 2));
            dw  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, MAX_WAIT)) : int'($urandom_range(0, 2));
            if ($urandom_range(0, 29) == 0) iw = MAX_WAIT + 1;
            run_instr(ins, iw, dw, -1, stopped);
            if (stopped) do_reset();
        end
        run_instr({OP_RTYPE, 20'h0, FN_NOR}, 0, 0, -1, stopped);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
